// File: rtl/ram_dma_pkg.sv
// rtl/ram_dma_pkg.sv - shared types and default sizes for the RAM port DMA
package ram_dma_pkg;
   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 16;
   localparam int LEN_W   = 10;
   localparam int MAX_LEN = 512;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;
endpackage

// File: rtl/ram_port_dma_if.sv
// rtl/ram_port_dma_if.sv - one port of the shared data RAM (DMA side is master)
interface ram_port_dma_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic              ram_read_en;
   logic              ram_write_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output ram_read_en, ram_write_en, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_read_en, ram_write_en, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ram_port_dma.sv
// rtl/ram_port_dma.sv - block copy between RAM regions, one word per read/write cycle pair
// Optional constant-fill mode is enabled by defining RAM_DMA_FILL_EN.
module ram_port_dma
   import ram_dma_pkg::*;
#(
   parameter int ADDR_W = ram_dma_pkg::ADDR_W,
   parameter int DATA_W = ram_dma_pkg::DATA_W,
   parameter int LEN_W  = ram_dma_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
`ifdef RAM_DMA_FILL_EN
   input  logic              fill_mode,
   input  logic [DATA_W-1:0] fill_value,
`endif
   output logic              busy,
   output logic              done,
   ram_port_dma_if.master    ram
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              fill_q, fill_d;
   logic [DATA_W-1:0] fval_q, fval_d;
   logic              start_fill;
   logic [DATA_W-1:0] start_fval;
   logic [LEN_W-1:0]  len_clamped;

`ifdef RAM_DMA_FILL_EN
   assign start_fill = fill_mode;
   assign start_fval = fill_value;
`else
   assign start_fill = 1'b0;
   assign start_fval = '0;
`endif

   assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
         fval_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         fval_q  <= fval_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      src_d            = src_q;
      dst_d            = dst_q;
      len_d            = len_q;
      cnt_d            = cnt_q;
      fill_d           = fill_q;
      fval_d           = fval_q;
      busy             = 1'b0;
      done             = 1'b0;
      ram.ram_read_en  = 1'b0;
      ram.ram_write_en = 1'b0;
      ram.ram_addr     = '0;
      ram.ram_wdata    = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               src_d  = src_addr;
               dst_d  = dst_addr;
               len_d  = len_clamped;
               cnt_d  = '0;
               fill_d = start_fill;
               fval_d = start_fval;
               if (len_clamped == '0)
                  state_d = DONE;
               else if (start_fill)
                  state_d = WRITE;
               else
                  state_d = READ;
            end
         end
         READ: begin
            busy            = 1'b1;
            ram.ram_read_en = 1'b1;
            ram.ram_addr    = src_q + ADDR_W'(cnt_q);
            state_d         = WRITE;
         end
         WRITE: begin
            busy             = 1'b1;
            ram.ram_write_en = 1'b1;
            ram.ram_addr     = dst_q + ADDR_W'(cnt_q);
            // RAM holds the word read last cycle, so write it straight through
            ram.ram_wdata    = fill_q ? fval_q : ram.ram_rdata;
            if (cnt_q == len_q - LEN_W'(1)) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + LEN_W'(1);
               state_d = fill_q ? WRITE : READ;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset masks the port immediately so an aborted write never lands
      if (rst) begin
         busy             = 1'b0;
         done             = 1'b0;
         ram.ram_read_en  = 1'b0;
         ram.ram_write_en = 1'b0;
         ram.ram_addr     = '0;
         ram.ram_wdata    = '0;
      end
   end

endmodule

// File: tb/tb_ram_port_dma.sv
// tb/tb_ram_port_dma.sv - randomized and directed checks of ram_port_dma against a trace model
module tb_ram_port_dma;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  src_addr;
   logic [8:0]  dst_addr;
   logic [9:0]  len;
   logic        busy;
   logic        done;
`ifdef RAM_DMA_FILL_EN
   logic        fill_mode;
   logic [15:0] fill_value;
`endif

   ram_port_dma_if #(.ADDR_W(9), .DATA_W(16)) ram_bus ();

   ram_port_dma dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
`ifdef RAM_DMA_FILL_EN
      .fill_mode  (fill_mode),
      .fill_value (fill_value),
`endif
      .busy       (busy),
      .done       (done),
      .ram        (ram_bus)
   );

   always #5 clk = ~clk;

   // Shared RAM: port 1 is the DMA, port 2 is the bench preload port
   logic [15:0] mem [0:511];
   logic        p2_we = 1'b0;
   logic [8:0]  p2_addr = '0;
   logic [15:0] p2_wdata = '0;

   always @(posedge clk) begin
      if (ram_bus.ram_write_en) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
      if (p2_we) mem[p2_addr] <= p2_wdata;
      if (ram_bus.ram_read_en) ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
   end

   logic [15:0] mdl [0:511];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [28:0] obs, input logic [28:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [28:0] observe();
      return {busy, done, ram_bus.ram_read_en, ram_bus.ram_write_en,
              ram_bus.ram_addr, ram_bus.ram_wdata};
   endfunction

   task automatic poke(input int a, input logic [15:0] d);
      @(negedge clk);
      p2_we = 1'b1; p2_addr = 9'(a); p2_wdata = d;
      mdl[a] = d;
      @(negedge clk);
      p2_we = 1'b0;
   endtask

   task automatic mem_check(input string tag);
      int diffs = 0;
      for (int a = 0; a < 512; a++) if (mem[a] !== mdl[a]) diffs++;
      check({"mem_", tag}, 29'(diffs), 29'd0);
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         #1 check($sformatf("%s_idle%0d", tag, c), observe(), 29'd0);
      end
   endtask

   // Expected per-cycle port activity computed from the copy rules; cycle 1 follows the start edge
   task automatic run(input int src, input int dst, input int len_in, input int restart_c,
                      input int abort_c, input bit fill, input logic [15:0] fv, input string tag);
      int L, done_c, last, k, a;
      logic [28:0] exp_v;
      logic [15:0] d;
      L      = (len_in > 512) ? 512 : len_in;
      done_c = (L == 0) ? 1 : (fill ? L + 1 : 2 * L + 1);
      last   = (abort_c > 0) ? abort_c + 2 : done_c;
      @(negedge clk);
      start = 1'b1; src_addr = 9'(src); dst_addr = 9'(dst); len = 10'(len_in);
`ifdef RAM_DMA_FILL_EN
      fill_mode = fill; fill_value = fv;
`endif
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         start = (c == restart_c);
         rst   = (c == abort_c);
         #1;
         exp_v = '0;
         if (abort_c > 0 && c >= abort_c) begin
            exp_v = '0;
         end else if (c == done_c) begin
            exp_v[27] = 1'b1;
         end else if (c < done_c) begin
            exp_v[28] = 1'b1;
            if (fill) begin
               k = c - 1;
               a = (dst + k) % 512;
               exp_v[25] = 1'b1; exp_v[24:16] = 9'(a); exp_v[15:0] = fv;
               mdl[a] = fv;
            end else if (c % 2 == 1) begin
               k = (c - 1) / 2;
               exp_v[26] = 1'b1; exp_v[24:16] = 9'((src + k) % 512);
            end else begin
               k = c / 2 - 1;
               a = (dst + k) % 512;
               d = mdl[(src + k) % 512];
               exp_v[25] = 1'b1; exp_v[24:16] = 9'(a); exp_v[15:0] = d;
               mdl[a] = d;
            end
         end
         check($sformatf("%s_c%0d", tag, c), observe(), exp_v);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
`ifdef RAM_DMA_FILL_EN
      fill_mode = 1'b0; fill_value = '0;
`endif
      repeat (3) @(negedge clk);
      #1 check("reset_outputs", observe(), 29'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("after_reset", observe(), 29'd0);

      for (int a = 0; a < 512; a++) begin
         @(negedge clk);
         p2_we = 1'b1; p2_addr = 9'(a); p2_wdata = 16'($urandom);
         mdl[a] = p2_wdata;
      end
      @(negedge clk);
      p2_we = 1'b0;

      for (int i = 0; i < 4; i++) poke(16 + i, 16'hA001 + 16'(i));
      run(16'h010, 16'h100, 4, 0, 0, 1'b0, 16'h0, "basic");
      idle_cycles("basic", 2);
      mem_check("basic");

      run(16'h050, 16'h060, 0, 0, 0, 1'b0, 16'h0, "zero");
      idle_cycles("zero", 1);
      mem_check("zero");

      run(16'h1FE, 16'h0FE, 4, 0, 0, 1'b0, 16'h0, "wrap");
      mem_check("wrap");

      run(16'h020, 16'h180, 4, 3, 0, 1'b0, 16'h0, "restart");
      idle_cycles("restart", 3);
      mem_check("restart");

      run(16'h030, 16'h1A0, 4, 0, 4, 1'b0, 16'h0, "abort");
      mem_check("abort");

      run(16'h040, 16'h0C0, 3, 0, 0, 1'b0, 16'h0, "b2b_a");
      run(16'h0C0, 16'h140, 2, 0, 0, 1'b0, 16'h0, "b2b_b");
      idle_cycles("b2b", 1);
      mem_check("b2b");

      run(16'h000, 16'h100, 600, 0, 0, 1'b0, 16'h0, "clamp");
      idle_cycles("clamp", 1);
      mem_check("clamp");

      for (int r = 0; r < 8; r++) begin
         run(int'($urandom_range(511)), int'($urandom_range(511)), int'($urandom_range(24, 1)),
             0, 0, 1'b0, 16'h0, $sformatf("rnd%0d", r));
         mem_check($sformatf("rnd%0d", r));
      end

`ifdef RAM_DMA_FILL_EN
      run(16'h000, 16'h020, 3, 0, 0, 1'b1, 16'h5A5A, "fill");
      idle_cycles("fill", 1);
      mem_check("fill");
      for (int r = 0; r < 3; r++) begin
         run(0, int'($urandom_range(511)), int'($urandom_range(16, 1)), 0, 0, 1'b1,
             16'($urandom), $sformatf("rfill%0d", r));
         mem_check($sformatf("rfill%0d", r));
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
